// File: rtl/exc_vector_ctrl.sv
// Exception-entry sequencer: saves EPC, fetches the vector byte and
// loads the PC with the handler address; otherwise passes addr_sel through.
module exc_vector_ctrl #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_ovfl,
    input  logic        exc_div0,
    input  logic [2:0]  ctrl_addr_sel,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  addr_sel,
    output logic        epc_write,
    output logic        pc_write,
    output logic [31:0] handler_addr,
    output logic [1:0]  cause,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        READ,
        LOAD,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  hbyte_q, hbyte_d;

    logic        unused_rdata;
    assign unused_rdata = ^mem_rdata[31:8];

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        hbyte_d   = hbyte_q;
        epc_write = 1'b0;
        pc_write  = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (exc_opcode) begin
                    cause_d = 2'd1;
                    state_d = SAVE;
                end else if (exc_ovfl) begin
                    cause_d = 2'd2;
                    state_d = SAVE;
                end else if (exc_div0) begin
                    cause_d = 2'd3;
                    state_d = SAVE;
                end
            end
            SAVE: begin
                epc_write = 1'b1;
                cnt_d     = MEM_LAT[3:0];
                state_d   = READ;
            end
            READ: begin
                cnt_d = cnt_q - 4'd1;
                // Data is valid on the last cycle of the read window.
                if (cnt_q == 4'd1) begin
                    hbyte_d = mem_rdata[7:0];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pc_write = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                cause_d = 2'd0;
                state_d = IDLE;
            end
            default: begin
                cause_d = 2'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Vectors 100/101/110 map causes 1/2/3.
    always_comb begin
        if (state_q == IDLE) begin
            addr_sel = ctrl_addr_sel;
        end else begin
            addr_sel = 3'd3 + {1'b0, cause_q};
        end
    end

    assign handler_addr = {24'd0, hbyte_q};
    assign cause        = cause_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cause_q <= 2'd0;
            cnt_q   <= 4'd0;
            hbyte_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            hbyte_q <= hbyte_d;
        end
    end

endmodule
